// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 datapath mux.
// Registers the selected word into a single-entry valid/ready output stage.
module mux_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic OWNER_A = 1'b1;
    localparam logic OWNER_B = 1'b0;
    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    state_t     state, state_n;
    logic       last_owner, last_owner_n;
    logic [7:0] cnt, cnt_n;
    logic       sel_n;
    logic       accept, xfer_a, xfer_b;

    assign gnt_a  = (state == OWN_A);
    assign gnt_b  = (state == OWN_B);
    assign accept = !out_valid || out_ready;
    assign xfer_a = gnt_a && req_a && accept;
    assign xfer_b = gnt_b && req_b && accept;

    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        state_n      = state;
        last_owner_n = last_owner;
        cnt_n        = cnt;
        sel_n        = sel;
        unique case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (req_a && (!req_b || last_owner == OWNER_B)) begin
                    state_n      = OWN_A;
                    last_owner_n = OWNER_A;
                    sel_n        = 1'b1;
                end else if (req_b) begin
                    state_n      = OWN_B;
                    last_owner_n = OWNER_B;
                    sel_n        = 1'b0;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    cnt_n = 8'd0;
                    if (req_b) begin
                        state_n      = OWN_B;
                        last_owner_n = OWNER_B;
                        sel_n        = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer_a) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = 8'd0;
                        if (req_b) begin
                            state_n      = OWN_B;
                            last_owner_n = OWNER_B;
                            sel_n        = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    cnt_n = 8'd0;
                    if (req_a) begin
                        state_n      = OWN_A;
                        last_owner_n = OWNER_A;
                        sel_n        = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer_b) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = 8'd0;
                        if (req_a) begin
                            state_n      = OWN_A;
                            last_owner_n = OWNER_A;
                            sel_n        = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= OWNER_B;
            cnt        <= 8'd0;
            sel        <= 1'b0;
        end else begin
            state      <= state_n;
            last_owner <= last_owner_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
        end
    end

    // Output stage: sel is already aligned with the grant, so it steers the capture directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else if (xfer_a || xfer_b) begin
            y         <= sel ? data_a : data_b;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter: reset, single stream, contention,
// backpressure, early release and lone-requester bursts.
module tb_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b, out_ready;
    logic [31:0] data_a, data_b;
    logic        gnt_a, gnt_b, sel, out_valid;
    logic [31:0] y;

    int checks   = 0;
    int failures = 0;

    mux_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b0;
        data_a    = '0;
        data_b    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Async reset mid-stream: outputs clear before the next edge.
        do_reset();
        req_a = 1'b1; data_a = 32'h1111_1111; out_ready = 1'b1;
        repeat (3) tick();
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        check("pre_rst_sel", {31'b0, sel}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gnt_a", {31'b0, gnt_a}, 32'd0);
        check("rst_gnt_b", {31'b0, gnt_b}, 32'd0);
        check("rst_sel", {31'b0, sel}, 32'd0);
        check("rst_y", y, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);

        // Single requester A.
        do_reset();
        req_a = 1'b1; data_a = 32'hAAAA_AAAA; out_ready = 1'b1;
        tick();
        check("sa_gnt_a", {31'b0, gnt_a}, 32'd1);
        check("sa_sel", {31'b0, sel}, 32'd1);
        check("sa_valid0", {31'b0, out_valid}, 32'd0);
        tick();
        check("sa_y1", y, 32'hAAAA_AAAA);
        check("sa_valid1", {31'b0, out_valid}, 32'd1);
        data_a = 32'h0000_0000;
        tick();
        check("sa_y2", y, 32'h0000_0000);
        check("sa_valid2", {31'b0, out_valid}, 32'd1);
        req_a = 1'b0;
        tick();
        check("sa_idle_gnt", {31'b0, gnt_a}, 32'd0);
        check("sa_idle_valid", {31'b0, out_valid}, 32'd0);

        // Contention: A wins first tie, then strict 4/4 alternation without gaps.
        do_reset();
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 32'h1111_1111; data_b = 32'h5555_5555;
        tick();
        check("ct_gnt_a_e1", {31'b0, gnt_a}, 32'd1);
        check("ct_gnt_b_e1", {31'b0, gnt_b}, 32'd0);
        for (int k = 2; k <= 17; k++) begin
            tick();
            check("ct_y", y, (((k - 2) / 4) % 2 == 0) ? 32'h1111_1111 : 32'h5555_5555);
            check("ct_valid", {31'b0, out_valid}, 32'd1);
            check("ct_gnt_a", {31'b0, gnt_a}, (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check("ct_sel", {31'b0, sel}, (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Backpressure: stall holds word, grant and burst count.
        do_reset();
        req_a = 1'b1; data_a = 32'hA5A5_A5A5; out_ready = 1'b1;
        tick();
        tick();
        check("bp_y0", y, 32'hA5A5_A5A5);
        out_ready = 1'b0;
        data_a    = 32'h1234_5678;
        req_b     = 1'b1;
        data_b    = 32'hBBBB_BBBB;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_y", y, 32'hA5A5_A5A5);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_gnt", {31'b0, gnt_a}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_resume_y", y, 32'h1234_5678);
        tick();
        check("bp_cnt_gnt_a", {31'b0, gnt_a}, 32'd1);
        tick();
        check("bp_rotate_gnt_b", {31'b0, gnt_b}, 32'd1);
        check("bp_rotate_y", y, 32'h1234_5678);
        tick();
        check("bp_b_first", y, 32'hBBBB_BBBB);

        // Early release by A after two transfers; B then gets a full burst.
        do_reset();
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 32'h0A0A_0A0A; data_b = 32'hDDDD_DDDD;
        repeat (3) tick();
        check("er_y_a2", y, 32'h0A0A_0A0A);
        req_a = 1'b0;
        tick();
        check("er_gnt_b", {31'b0, gnt_b}, 32'd1);
        check("er_gap_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("er_y_d1", y, 32'hDDDD_DDDD);
        req_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("er_y_d", y, 32'hDDDD_DDDD);
            check("er_hold_gnt_b", {31'b0, gnt_b}, 32'd1);
        end
        tick();
        check("er_y_d4", y, 32'hDDDD_DDDD);
        check("er_back_to_a", {31'b0, gnt_a}, 32'd1);
        tick();
        check("er_y_a_again", y, 32'h0A0A_0A0A);

        // Lone requester B: ten back-to-back words across burst boundaries.
        do_reset();
        req_b = 1'b1; data_b = 32'hB000_0000; out_ready = 1'b1;
        tick();
        check("lb_gnt_b", {31'b0, gnt_b}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lb_y", y, 32'hB000_0000 + 32'(i));
            check("lb_valid", {31'b0, out_valid}, 32'd1);
            check("lb_gnt_b_held", {31'b0, gnt_b}, 32'd1);
            check("lb_sel", {31'b0, sel}, 32'd0);
            data_b = 32'hB000_0000 + 32'(i + 1);
        end
        req_b = 1'b0;
        tick();
        check("lb_release", {31'b0, gnt_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the shared 32-bit 2:1 datapath mux and sequences access to it. Each requester presents a word with a request; the arbiter grants one side at a time, steers the mux select, and registers the selected word into a single-entry output stage with valid/ready flow control. A burst limit forces rotation so neither requester can starve the other.

## Interface
- WIDTH, 32, data width of both inputs and the output.
- MAX_BURST, 4, transfers allowed per grant before forced rotation when the other side is requesting; legal range 1..255.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_a  input  1  requester A has a word on data_a.
- data_a  input  WIDTH  requester A word; held stable while req_a is high and not yet transferred.
- req_b  input  1  requester B has a word on data_b.
- data_b  input  WIDTH  requester B word; same stability rule.
- out_ready  input  1  downstream accepts y this cycle.
- gnt_a  output  1  A owns the mux (registered).
- gnt_b  output  1  B owns the mux (registered).
- sel  output  1  mux select: 1 = data_a, 0 = data_b (registered).
- y  output  WIDTH  registered output word.
- out_valid  output  1  y holds a word not yet accepted.

## Operation
- States: IDLE, OWN_A, OWN_B. gnt_a = (state==OWN_A), gnt_b = (state==OWN_B); never both high.
- Internal: last_owner (1 bit, reset = B), burst counter cnt (8 bits, reset 0).
- accept = !out_valid || out_ready. Transfer from X = gnt_x && req_x && accept.
- On transfer: y <= (sel ? data_a : data_b), out_valid <= 1. Else if out_ready: out_valid <= 0. Else y, out_valid hold.
- IDLE: both req -> own the side != last_owner; only one req -> that side; none -> stay. cnt <= 0; last_owner <= new owner; sel <= 1 for A, 0 for B.
- OWN_X, req_x low: req_other high -> OWN_other (cnt 0, last_owner, sel updated); else IDLE.
- OWN_X, transfer with cnt==MAX_BURST-1: req_other high -> OWN_other, cnt 0; else stay, cnt 0.
- OWN_X, transfer otherwise: cnt <= cnt+1. No transfer, req_x high: hold state and cnt.
- sel holds its last value in IDLE.
- Dropping req_x while granted and untransferred abandons that word; no error signalled.

## Timing
- Reset (async, immediate): state IDLE, gnt_a=0, gnt_b=0, sel=0, y=0, out_valid=0, cnt=0, last_owner=B (A wins first tie).
- Request latency: req in IDLE at cycle n -> gnt at n+1 -> transfer at end of n+1 -> out_valid/y at n+2.
- While owning with out_ready high: one word per cycle, no bubbles.
- Rotation: after owner's MAX_BURST-th transfer, other side's gnt asserts the next cycle; its first transfer that cycle; zero idle cycles at switch.
- Backpressure: out_valid=1, out_ready=0 -> no transfer, y stable, cnt frozen, grant held.
- Simultaneous req rise from IDLE: round-robin via last_owner only.
- rst_n low mid-transfer: pending y word discarded; first post-reset grant goes to A if both request.

## Test plan
- Reset: stream active, pull rst_n low between edges -> gnt_a, gnt_b, sel, y, out_valid all 0 immediately, before next clk edge.
- Single A: req_a=1, data_a=AAAAAAAA then 00000000, out_ready=1 -> gnt_a=1, sel=1 at cycle 1; y=AAAAAAAA out_valid=1 cycle 2; y=00000000 cycle 3.
- Contention, MAX_BURST=4: req_a, req_b high from reset, data_b=55555555 -> exactly 4 A words, then 4 words of 55555555 with sel=0, alternating, no out_valid gaps.
- Backpressure: y=A5A5A5A5 out_valid=1, out_ready=0 for 3 cycles -> y holds A5A5A5A5, no transfer, cnt unchanged; first transfer the cycle out_ready rises.
- Early release: A drops req_a after 2 transfers, req_b high with data_b=DDDDDDDD -> gnt_b next cycle, DDDDDDDD appears one cycle later, B gets full 4-word burst.
- Lone requester: only req_b high for 10 words -> gnt_b held continuously, 10 consecutive out_valid words, no IDLE cycle at burst boundaries.
